// File: rtl/adpcm_mc.sv
// Multi-channel IMA ADPCM codec: one bit-serial encode/decode engine shared by
// CH_N channels, each with its own predictor and step index, toggle-request handshake.
module adpcm_mc #(
  parameter int unsigned CH_N = 4,
  parameter int unsigned CH_W = (CH_N > 1) ? $clog2(CH_N) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
  input  logic               sel_rx,
  input  logic [CH_W-1:0]    ch,
  input  logic               req,
  input  logic signed [15:0] rx_pcm,
  input  logic [3:0]         rx_adpcm,
  output logic               ack,
  output logic [3:0]         tx_adpcm,
  output logic signed [15:0] tx_pcm,
  output logic               busy,
  output logic               ovf
);

  localparam int unsigned IDX_MAX = 88;

  localparam logic [14:0] STEP_TAB [89] = '{
    15'd7,     15'd8,     15'd9,     15'd10,    15'd11,    15'd12,    15'd13,    15'd14,
    15'd16,    15'd17,    15'd19,    15'd21,    15'd23,    15'd25,    15'd28,    15'd31,
    15'd34,    15'd37,    15'd41,    15'd45,    15'd50,    15'd55,    15'd60,    15'd66,
    15'd73,    15'd80,    15'd88,    15'd97,    15'd107,   15'd118,   15'd130,   15'd143,
    15'd157,   15'd173,   15'd190,   15'd209,   15'd230,   15'd253,   15'd279,   15'd307,
    15'd337,   15'd371,   15'd408,   15'd449,   15'd494,   15'd544,   15'd598,   15'd658,
    15'd724,   15'd796,   15'd876,   15'd963,   15'd1060,  15'd1166,  15'd1282,  15'd1411,
    15'd1552,  15'd1707,  15'd1878,  15'd2066,  15'd2272,  15'd2499,  15'd2749,  15'd3024,
    15'd3327,  15'd3660,  15'd4026,  15'd4428,  15'd4871,  15'd5358,  15'd5894,  15'd6484,
    15'd7132,  15'd7845,  15'd8630,  15'd9493,  15'd10442, 15'd11487, 15'd12635, 15'd13899,
    15'd15289, 15'd16818, 15'd18500, 15'd20350, 15'd22385, 15'd24623, 15'd27086, 15'd29794,
    15'd32767
  };

  typedef enum logic [2:0] {IDLE, LOAD, Q2, Q1, Q0, UPD, ACK} state_t;

  state_t state, state_d;

  logic signed [15:0] pred_mem [CH_N];
  logic [6:0]         idx_mem  [CH_N];

  logic               req_q;
  logic [CH_W-1:0]    ch_q, ch_d;
  logic               dec_q, dec_d;
  logic signed [15:0] pcm_q, pcm_d;
  logic [3:0]         code_q, code_d;
  logic signed [15:0] pred_q, pred_d;
  logic [6:0]         idx_q, idx_d;
  logic [14:0]        step_q, step_d;
  logic [16:0]        diff_q, diff_d;
  logic [16:0]        vpd_q, vpd_d;
  logic               sign_q, sign_d;
  logic [2:0]         mag_q, mag_d;
  logic               ack_d, busy_d, ovf_d;
  logic [3:0]         tx_adpcm_d;
  logic signed [15:0] tx_pcm_d;
  logic               clr, wr_en;

  logic               req_edge;
  logic signed [15:0] pred_rd;
  logic [6:0]         idx_rd;
  logic [16:0]        dsum;
  logic [17:0]        psum;
  logic [7:0]         adj, isum;
  logic signed [15:0] pred_new;
  logic [6:0]         idx_new;
  logic [16:0]        s_cur;
  logic [1:0]         k;
  logic               rbit;

  assign req_edge = enable && (req != req_q);
  assign pred_rd  = pred_mem[ch_q];
  assign idx_rd   = idx_mem[ch_q];
  assign dsum     = {pcm_q[15], pcm_q} - {pred_rd[15], pred_rd};

  // Saturating predictor and clamped index update, used in UPD
  assign psum = sign_q ? ({{2{pred_q[15]}}, pred_q} - {1'b0, vpd_q})
                       : ({{2{pred_q[15]}}, pred_q} + {1'b0, vpd_q});
  assign pred_new = ($signed(psum) > 18'sd32767)  ? 16'sh7FFF :
                    ($signed(psum) < -18'sd32768) ? 16'sh8000 : psum[15:0];

  always_comb begin
    adj = 8'hFF;
    case (mag_q)
      3'd4:    adj = 8'd2;
      3'd5:    adj = 8'd4;
      3'd6:    adj = 8'd6;
      3'd7:    adj = 8'd8;
      default: adj = 8'hFF;
    endcase
  end

  assign isum    = {1'b0, idx_q} + adj;
  assign idx_new = isum[7] ? 7'd0 : (isum > 8'(IDX_MAX)) ? 7'(IDX_MAX) : isum[6:0];

  // Magnitude-bit slice for the current quantiser state
  always_comb begin
    k     = 2'd0;
    s_cur = 17'(step_q >> 2);
    case (state)
      Q2: begin k = 2'd2; s_cur = 17'(step_q); end
      Q1: begin k = 2'd1; s_cur = 17'(step_q >> 1); end
      default: ;
    endcase
  end

  assign rbit = dec_q ? code_q[k] : (diff_q >= s_cur);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  always_comb begin
    state_d    = state;
    ch_d       = ch_q;
    dec_d      = dec_q;
    pcm_d      = pcm_q;
    code_d     = code_q;
    pred_d     = pred_q;
    idx_d      = idx_q;
    step_d     = step_q;
    diff_d     = diff_q;
    vpd_d      = vpd_q;
    sign_d     = sign_q;
    mag_d      = mag_q;
    ack_d      = 1'b0;
    busy_d     = busy;
    ovf_d      = ovf;
    tx_adpcm_d = tx_adpcm;
    tx_pcm_d   = tx_pcm;
    clr        = 1'b0;
    wr_en      = 1'b0;

    if (!enable) begin
      state_d = IDLE;
      busy_d  = 1'b0;
      ovf_d   = 1'b0;
      clr     = 1'b1;
    end else begin
      if (req_edge && state != IDLE) ovf_d = 1'b1;
      case (state)
        IDLE: if (req_edge) begin
          ch_d    = (32'(ch) < CH_N) ? ch : '0;
          dec_d   = sel_rx;
          pcm_d   = rx_pcm;
          code_d  = rx_adpcm;
          busy_d  = 1'b1;
          state_d = LOAD;
        end
        LOAD: begin
          pred_d  = pred_rd;
          idx_d   = idx_rd;
          step_d  = STEP_TAB[idx_rd];
          vpd_d   = 17'(STEP_TAB[idx_rd] >> 3);
          sign_d  = dec_q ? code_q[3] : dsum[16];
          diff_d  = dsum[16] ? (17'd0 - dsum) : dsum;
          mag_d   = 3'd0;
          state_d = Q2;
        end
        Q2, Q1, Q0: begin
          mag_d[k] = rbit;
          if (rbit) vpd_d = vpd_q + s_cur;
          if (rbit && !dec_q) diff_d = diff_q - s_cur;
          state_d = (state == Q2) ? Q1 : (state == Q1) ? Q0 : UPD;
        end
        UPD: begin
          wr_en      = 1'b1;
          tx_pcm_d   = pred_new;
          tx_adpcm_d = dec_q ? 4'h0 : {sign_q, mag_q};
          ack_d      = 1'b1;
          state_d    = ACK;
        end
        ACK: begin
          busy_d  = 1'b0;
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      req_q    <= req;
      ch_q     <= '0;
      dec_q    <= 1'b0;
      pcm_q    <= '0;
      code_q   <= '0;
      pred_q   <= '0;
      idx_q    <= '0;
      step_q   <= '0;
      diff_q   <= '0;
      vpd_q    <= '0;
      sign_q   <= 1'b0;
      mag_q    <= '0;
      ack      <= 1'b0;
      busy     <= 1'b0;
      ovf      <= 1'b0;
      tx_adpcm <= '0;
      tx_pcm   <= '0;
    end else begin
      req_q    <= req;
      ch_q     <= ch_d;
      dec_q    <= dec_d;
      pcm_q    <= pcm_d;
      code_q   <= code_d;
      pred_q   <= pred_d;
      idx_q    <= idx_d;
      step_q   <= step_d;
      diff_q   <= diff_d;
      vpd_q    <= vpd_d;
      sign_q   <= sign_d;
      mag_q    <= mag_d;
      ack      <= ack_d;
      busy     <= busy_d;
      ovf      <= ovf_d;
      tx_adpcm <= tx_adpcm_d;
      tx_pcm   <= tx_pcm_d;
    end
  end

  // Per-channel state; only the captured channel is ever written
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      for (int i = 0; i < int'(CH_N); i++) begin
        pred_mem[i] <= '0;
        idx_mem[i]  <= '0;
      end
    end else if (wr_en) begin
      pred_mem[ch_q] <= pred_new;
      idx_mem[ch_q]  <= idx_new;
    end
  end

endmodule

// File: tb/tb_adpcm_mc.sv
// Directed bench for adpcm_mc: hand-computed vectors plus a reference IMA model
// for the sine round-trip and saturation runs.
module tb_adpcm_mc;

  localparam int unsigned CH_N = 4;
  localparam int unsigned CH_W = 2;

  logic               clk;
  logic               rst;
  logic               enable;
  logic               sel_rx;
  logic [CH_W-1:0]    ch;
  logic               req;
  logic signed [15:0] rx_pcm;
  logic [3:0]         rx_adpcm;
  logic               ack;
  logic [3:0]         tx_adpcm;
  logic signed [15:0] tx_pcm;
  logic               busy;
  logic               ovf;

  int total;
  int bad;
  int m_pred [CH_N];
  int m_idx  [CH_N];
  int enc_code [1000];
  int enc_pcm  [1000];

  int step_tab [89] = '{
    7, 8, 9, 10, 11, 12, 13, 14, 16, 17, 19, 21, 23, 25, 28, 31, 34, 37, 41, 45,
    50, 55, 60, 66, 73, 80, 88, 97, 107, 118, 130, 143, 157, 173, 190, 209, 230,
    253, 279, 307, 337, 371, 408, 449, 494, 544, 598, 658, 724, 796, 876, 963,
    1060, 1166, 1282, 1411, 1552, 1707, 1878, 2066, 2272, 2499, 2749, 3024, 3327,
    3660, 4026, 4428, 4871, 5358, 5894, 6484, 7132, 7845, 8630, 9493, 10442,
    11487, 12635, 13899, 15289, 16818, 18500, 20350, 22385, 24623, 27086, 29794,
    32767
  };
  int idx_adj [8] = '{-1, -1, -1, -1, 2, 4, 6, 8};

  adpcm_mc #(.CH_N(CH_N)) dut (
    .clk      (clk),
    .rst      (rst),
    .enable   (enable),
    .sel_rx   (sel_rx),
    .ch       (ch),
    .req      (req),
    .rx_pcm   (rx_pcm),
    .rx_adpcm (rx_adpcm),
    .ack      (ack),
    .tx_adpcm (tx_adpcm),
    .tx_pcm   (tx_pcm),
    .busy     (busy),
    .ovf      (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < int'(CH_N); i++) begin
      m_pred[i] = 0;
      m_idx[i]  = 0;
    end
  endtask

  // Reference IMA codec step (classic successive-halving formulation)
  task automatic model_op(input bit dec, input int c, input int pcm, input int code,
                          output int oc, output int op);
    int step, diff, vp, sgn, mag, p, ix;
    p    = m_pred[c];
    step = step_tab[m_idx[c]];
    mag  = 0;
    sgn  = 0;
    if (dec) begin
      sgn = (code >> 3) & 1;
      mag = code & 7;
    end else begin
      diff = pcm - p;
      if (diff < 0) begin sgn = 1; diff = -diff; end
      if (diff >= step)     begin mag += 4; diff -= step; end
      if (diff >= step / 2) begin mag += 2; diff -= step / 2; end
      if (diff >= step / 4) mag += 1;
    end
    vp = step / 8;
    if (mag >= 4)     vp += step;
    if ((mag & 2) != 0) vp += step / 2;
    if ((mag & 1) != 0) vp += step / 4;
    p = (sgn != 0) ? p - vp : p + vp;
    if (p > 32767)  p = 32767;
    if (p < -32768) p = -32768;
    ix = m_idx[c] + idx_adj[mag];
    if (ix < 0)  ix = 0;
    if (ix > 88) ix = 88;
    m_pred[c] = p;
    m_idx[c]  = ix;
    oc = dec ? 0 : sgn * 8 + mag;
    op = p;
  endtask

  // One handshake: toggle req, scramble inputs after capture, time the ack
  task automatic run_op(input bit dec, input int c, input int pcm, input int code,
                        input string tag, output int oc, output int op);
    int n;
    @(negedge clk);
    sel_rx   = dec;
    ch       = CH_W'(c);
    rx_pcm   = 16'(pcm);
    rx_adpcm = 4'(code);
    req      = ~req;
    @(negedge clk);
    n = 1;
    rx_pcm   = 16'($urandom);
    rx_adpcm = 4'($urandom);
    sel_rx   = ~dec;
    ch       = CH_W'($urandom);
    check({tag, "_busy_hi"}, int'(busy), 1);
    while (!ack && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_lat"}, n - 1, 5);
    oc = int'(tx_adpcm);
    op = int'(tx_pcm);
    @(negedge clk);
    check({tag, "_ack_pulse"}, int'(ack), 0);
    check({tag, "_busy_lo"}, int'(busy), 0);
  endtask

  task automatic xact(input bit dec, input int c, input int pcm, input int code,
                      input string tag, output int oc, output int op);
    int eoc, eop;
    model_op(dec, c, pcm, code, eoc, eop);
    run_op(dec, c, pcm, code, tag, oc, op);
    check({tag, "_code"}, oc, eoc);
    check({tag, "_pcm"}, op, eop);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int oc, op, acks;
    real x;
    total = 0;
    bad   = 0;
    rst = 1'b1; enable = 1'b0; sel_rx = 1'b0; ch = '0; req = 1'b0;
    rx_pcm = '0; rx_adpcm = '0;
    model_clear();
    repeat (2) @(negedge clk);
    check("rst_ack", int'(ack), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_ovf", int'(ovf), 0);
    check("rst_txa", int'(tx_adpcm), 0);
    check("rst_txp", int'(tx_pcm), 0);
    rst = 1'b0;
    enable = 1'b1;

    xact(1'b0, 0, 1000, 0, "pre", oc, op);

    // Overrun: second toggle while busy is dropped and latches ovf
    model_op(1'b0, 1, 500, 0, oc, op);
    @(negedge clk); sel_rx = 1'b0; ch = 2'd1; rx_pcm = 16'sd500; req = ~req;
    repeat (2) @(negedge clk);
    req = ~req;
    acks = 0;
    repeat (12) begin @(negedge clk); acks += int'(ack); end
    check("ovr_acks", acks, 1);
    check("ovr_pcm", int'(tx_pcm), op);
    check("ovr_ovf", int'(ovf), 1);
    repeat (5) @(negedge clk);
    check("ovr_ovf_sticky", int'(ovf), 1);

    // Reset held two cycles while the engine sits in Q1
    @(negedge clk); sel_rx = 1'b0; ch = 2'd0; rx_pcm = 16'sd2000; req = ~req;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    acks = 0;
    repeat (2) begin @(negedge clk); acks += int'(ack); end
    rst = 1'b0;
    repeat (8) begin @(negedge clk); acks += int'(ack); end
    check("midrst_acks", acks, 0);
    check("midrst_txa", int'(tx_adpcm), 0);
    check("midrst_txp", int'(tx_pcm), 0);
    check("midrst_busy", int'(busy), 0);
    check("midrst_ovf", int'(ovf), 0);
    model_clear();

    // Hand-computed encode vectors and channel isolation
    xact(1'b0, 0, 1000, 0, "e0", oc, op);
    check("e0_hand_code", oc, 7);
    check("e0_hand_pcm", op, 11);
    xact(1'b0, 1, -1000, 0, "e1", oc, op);
    check("e1_hand_code", oc, 15);
    check("e1_hand_pcm", op, -11);
    xact(1'b0, 0, 11, 0, "e2", oc, op);
    check("e2_hand_code", oc, 0);
    check("e2_hand_pcm", op, 13);
    xact(1'b0, 0, 13, 0, "e3", oc, op);
    check("e3_hand_code", oc, 0);
    check("e3_hand_pcm", op, 14);
    xact(1'b0, 1, -11, 0, "e4", oc, op);
    check("e4_hand_code", oc, 0);
    check("e4_hand_pcm", op, -9);

    // Overrun then enable low mid-flight: ovf clears, no ack, state cleared
    @(negedge clk); sel_rx = 1'b0; ch = 2'd0; rx_pcm = 16'sd3000; req = ~req;
    repeat (2) @(negedge clk);
    req = ~req;
    @(negedge clk);
    check("en_ovf_set", int'(ovf), 1);
    enable = 1'b0;
    acks = 0;
    @(negedge clk);
    acks += int'(ack);
    check("en_ovf_clr", int'(ovf), 0);
    check("en_busy_clr", int'(busy), 0);
    enable = 1'b1;
    repeat (8) begin @(negedge clk); acks += int'(ack); end
    check("en_abort_acks", acks, 0);
    model_clear();
    xact(1'b0, 0, 1000, 0, "en_cleared", oc, op);
    check("en_cleared_hand_pcm", op, 11);

    // Sine encode on ch2, clear via enable, decode the codes back
    for (int i = 0; i < 1000; i++) begin
      x = 12000.0 * $sin(6.283185307179586 * real'(i) / 50.0);
      xact(1'b0, 2, $rtoi(x), 0, "sin_enc", oc, op);
      enc_code[i] = oc;
      enc_pcm[i]  = op;
    end
    @(negedge clk); enable = 1'b0;
    @(negedge clk); enable = 1'b1;
    model_clear();
    for (int i = 0; i < 1000; i++) begin
      xact(1'b1, 2, 0, enc_code[i], "sin_dec", oc, op);
      check("rt_pcm", op, enc_pcm[i]);
    end

    // Saturation on ch3 at both rails; index pinned at 88
    for (int i = 0; i < 100; i++) xact(1'b1, 3, 0, 7, "sat_pos", oc, op);
    check("sat_pos_hand", op, 32767);
    for (int i = 0; i < 100; i++) xact(1'b1, 3, 0, 15, "sat_neg", oc, op);
    check("sat_neg_hand", op, -32768);
    xact(1'b1, 3, 0, 0, "sat_idx", oc, op);
    check("sat_idx_hand", op, -28673);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
